mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the CPU data bus, in parallel with DataMemory; consumes CPU bus cycles (AddressBus, DataBusOut, ControlBus) decoded to its address window.
- CPU stores bytes into a TX FIFO; a serializer emits 8N1 frames on a single output pin at a programmable bit period.
- Provides status, control and divisor registers plus a level interrupt, so programs run under the cycle-bounded bench can report output.

---
 rtl/mmio_uart_tx.sv | 238 +++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, status/control/divisor
// registers, serializer with a programmable bit period, and a level interrupt.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 4
) (
    input  logic        InputClk,
    input  logic        rst,
    input  logic [31:0] AddressBus,
    input  logic [31:0] DataBusOut,
    input  logic [2:0]  ControlBus,
    output logic        MmioHit,
    output logic [31:0] MmioDataOutput,
    output logic        tx,
    output logic        tx_busy,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_enable;
    logic          r_irq_en;
    logic          r_ovf;
    logic [15:0]   r_divisor;
    logic [15:0]   r_period;
    logic [15:0]   r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_rd;
    logic          w_wr;
    logic [1:0]    w_off;
    logic          w_wr_txdata;
    logic          w_wr_status;
    logic          w_wr_ctrl;
    logic          w_wr_div;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_tick;
    logic [6:0]    w_count7;
    logic [7:0]    w_head;
    logic [31:0]   w_rdata;
    logic          w_unused_bits;

    assign MmioHit     = (AddressBus[31:4] == BASE_ADDR[31:4]);
    assign w_rd        = MmioHit & ControlBus[1];
    assign w_wr        = MmioHit & ControlBus[2];
    assign w_off       = AddressBus[3:2];
    assign w_wr_txdata = w_wr & (w_off == 2'd0);
    assign w_wr_status = w_wr & (w_off == 2'd1);
    assign w_wr_ctrl   = w_wr & (w_off == 2'd2);
    assign w_wr_div    = w_wr & (w_off == 2'd3);

    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_empty  = (r_count == {CW{1'b0}});
    // A full FIFO still accepts a byte when the serializer pops in the same cycle.
    assign w_push   = w_wr_txdata & (~w_full | w_pop);
    assign w_count7 = 7'(r_count);
    assign w_head   = r_mem[r_rd_ptr];
    assign w_tick   = (r_cnt == (r_period - 16'd1));

    assign tx      = r_tx;
    assign tx_busy = (r_state != ST_IDLE);
    assign irq     = r_irq_en & w_empty & ~tx_busy;

    assign w_unused_bits = &{1'b0, AddressBus[1:0], DataBusOut[31:16], ControlBus[0]};

    // Read-data mux: combinational, no side effects, zero outside a read hit.
    always_comb begin
        w_rdata = 32'd0;
        case (w_off)
            2'd0:    w_rdata = 32'd0;
            2'd1:    w_rdata = {17'd0, w_count7, 4'd0, r_ovf, tx_busy, w_empty, w_full};
            2'd2:    w_rdata = {30'd0, r_irq_en, r_enable};
            2'd3:    w_rdata = {16'd0, r_divisor};
            default: w_rdata = 32'd0;
        endcase
        if (w_rd) begin
            MmioDataOutput = w_rdata;
        end else begin
            MmioDataOutput = 32'd0;
        end
    end

    // Control, divisor and sticky overflow registers.
    always_ff @(posedge InputClk or negedge rst) begin
        if (!rst) begin
            r_enable  <= 1'b0;
            r_irq_en  <= 1'b0;
            r_divisor <= 16'(CLKS_PER_BIT);
            r_ovf     <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_enable <= DataBusOut[0];
                r_irq_en <= DataBusOut[1];
            end
            if (w_wr_div) begin
                r_divisor <= (DataBusOut[15:0] == 16'd0) ? 16'd1 : DataBusOut[15:0];
            end
            if (w_wr_txdata & ~w_push) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status & DataBusOut[3]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge InputClk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= DataBusOut[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge InputClk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Serializer state register.
    always_ff @(posedge InputClk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Serializer next-state logic; the pop happens on the IDLE exit cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_enable & ~w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (w_tick & (r_bit == 3'd7)) begin
                    w_state_nxt = ST_STOP;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Shift register, latched bit period, bit-period counter and bit index.
    always_ff @(posedge InputClk or negedge rst) begin
        if (!rst) begin
            r_shift  <= 8'd0;
            r_period <= 16'(CLKS_PER_BIT);
            r_cnt    <= 16'd0;
            r_bit    <= 3'd0;
        end else if (w_pop) begin
            r_shift  <= w_head;
            r_period <= r_divisor;
            r_cnt    <= 16'd0;
            r_bit    <= 3'd0;
        end else if (r_state != ST_IDLE) begin
            if (w_tick) begin
                r_cnt <= 16'd0;
                if (r_state == ST_DATA) begin
                    r_bit <= r_bit + 3'd1;
                end
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    // Registered line driver: follows the serializer state one clock later.
    always_ff @(posedge InputClk or negedge rst) begin
        if (!rst) begin
            r_tx <= 1'b1;
        end else begin
            case (r_state)
                ST_START: r_tx <= 1'b0;
                ST_DATA:  r_tx <= r_shift[r_bit];
                default:  r_tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: randomized bytes and divisors checked
// against a frame-schedule model of the serial line and a queue model of the FIFO.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 8;

    logic        clk;
    logic        rst;
    logic [31:0] AddressBus;
    logic [31:0] DataBusOut;
    logic [2:0]  ControlBus;
    logic        MmioHit;
    logic [31:0] MmioDataOutput;
    logic        tx;
    logic        tx_busy;
    logic        irq;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (4)
    ) dut (
        .InputClk       (clk),
        .rst            (rst),
        .AddressBus     (AddressBus),
        .DataBusOut     (DataBusOut),
        .ControlBus     (ControlBus),
        .MmioHit        (MmioHit),
        .MmioDataOutput (MmioDataOutput),
        .tx             (tx),
        .tx_busy        (tx_busy),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference model: FIFO contents, sticky overflow, and scheduled frames.
    logic [7:0] mq[$];
    bit         m_ovf = 1'b0;
    int         fr_start[$];
    int         fr_per[$];
    logic [7:0] fr_byte[$];

    task automatic model_push(input logic [7:0] b);
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovf = 1'b1;
    endtask

    // A frame whose start bit first appears on the line in cycle s.
    task automatic schedule(input int s, input int p);
        fr_start.push_back(s);
        fr_per.push_back(p);
        fr_byte.push_back(mq.pop_front());
    endtask

    function automatic logic exp_tx(input int c);
        logic r;
        int   j;
        logic [7:0] b;
        r = 1'b1;
        for (int i = 0; i < fr_start.size(); i++) begin
            if (c >= fr_start[i] && c < fr_start[i] + 10 * fr_per[i]) begin
                j = (c - fr_start[i]) / fr_per[i];
                b = fr_byte[i];
                if (j == 0) r = 1'b0;
                else if (j == 9) r = 1'b1;
                else r = b[j-1];
            end
        end
        return r;
    endfunction

    function automatic logic exp_busy(input int c);
        logic r;
        r = 1'b0;
        for (int i = 0; i < fr_start.size(); i++) begin
            if (c >= fr_start[i] - 1 && c < fr_start[i] - 1 + 10 * fr_per[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_status(input logic busy);
        int n;
        n = mq.size();
        return {17'd0, 7'(n), 4'd0, m_ovf, busy, (n == 0), (n == DEPTH)};
    endfunction

    // Line monitor: compares tx and tx_busy to the frame schedule every cycle.
    bit mon_en = 1'b0;
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            check_eq("tx_line", 32'(tx), 32'(exp_tx(cyc)));
            check_eq("tx_busy", 32'(tx_busy), 32'(exp_busy(cyc)));
        end
    end

    task automatic bus_xfer(input logic [1:0] off, input logic [31:0] d, input logic [2:0] ctl,
                            output int edge_c, output logic [31:0] rd);
        @(negedge clk);
        AddressBus = BASE | {28'd0, off, 2'b00};
        DataBusOut = d;
        ControlBus = ctl;
        #1 rd = MmioDataOutput;
        @(posedge clk);
        #1;
        edge_c = cyc;
        ControlBus = 3'b000;
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [31:0] d, output int edge_c);
        logic [31:0] junk;
        bus_xfer(off, d, 3'b100, edge_c, junk);
    endtask

    task automatic bus_read(input logic [1:0] off, output logic [31:0] rd);
        @(negedge clk);
        AddressBus = BASE | {28'd0, off, 2'b00};
        ControlBus = 3'b010;
        #1 rd = MmioDataOutput;
        ControlBus = 3'b000;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int          e;
        int          e2;
        int          p;
        int          tgt;
        logic [7:0]  b;
        logic [7:0]  b2;
        logic [31:0] rd;

        rst        = 1'b0;
        AddressBus = 32'd0;
        DataBusOut = 32'd0;
        ControlBus = 3'b000;
        wait_cycles(3);
        check_eq("rst_tx", 32'(tx), 32'd1);
        check_eq("rst_busy", 32'(tx_busy), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        @(negedge clk) rst = 1'b1;

        // Register map after reset.
        bus_read(2'd0, rd); check_eq("rd_txdata", rd, 32'h0);
        bus_read(2'd1, rd); check_eq("rd_status", rd, 32'h2);
        bus_read(2'd2, rd); check_eq("rd_ctrl", rd, 32'h0);
        bus_read(2'd3, rd); check_eq("rd_div", rd, 32'h4);

        // Address decode: low byte-address bits ignored, outside window no hit.
        @(negedge clk);
        AddressBus = BASE + 32'hF;
        ControlBus = 3'b010;
        #1 check_eq("hit_in", 32'(MmioHit), 32'd1);
        check_eq("rd_low_bits", MmioDataOutput, 32'h4);
        ControlBus = 3'b100;
        AddressBus = BASE + 32'hC;
        #1 check_eq("no_rd_en", MmioDataOutput, 32'h0);
        AddressBus = BASE + 32'h1C;
        ControlBus = 3'b010;
        #1 check_eq("hit_out", 32'(MmioHit), 32'd0);
        check_eq("rd_out", MmioDataOutput, 32'h0);
        ControlBus = 3'b000;

        mon_en = 1'b1;

        // Single frame 0xA5 at divisor 4, then random bytes and divisors.
        bus_write(2'd2, 32'h1, e);
        bus_write(2'd0, 32'hA5, e);
        model_push(8'hA5);
        schedule(e + 2, 4);
        wait_cycles(43);
        bus_read(2'd1, rd); check_eq("status_after_a5", rd, exp_status(1'b0));
        for (int k = 0; k < 4; k++) begin
            p = $urandom_range(1, 6);
            b = 8'($urandom);
            bus_write(2'd3, 32'(p), e);
            bus_write(2'd0, {24'd0, b}, e);
            model_push(b);
            schedule(e + 2, p);
            wait_cycles(10 * p + 3);
            bus_read(2'd3, rd); check_eq("div_rb", rd, 32'(p));
        end

        // Interrupt when enabled, FIFO empty and serializer idle.
        bus_write(2'd2, 32'h3, e);
        check_eq("irq_on", 32'(irq), 32'd1);
        bus_write(2'd2, 32'h0, e);
        check_eq("irq_off", 32'(irq), 32'd0);

        // Fill past depth with the serializer disabled.
        for (int v = 1; v <= 9; v++) begin
            bus_write(2'd0, 32'(v), e);
            model_push(8'(v));
        end
        bus_read(2'd1, rd); check_eq("status_full", rd, exp_status(1'b0));
        bus_write(2'd1, 32'h8, e);
        m_ovf = 1'b0;
        bus_read(2'd1, rd); check_eq("status_w1c", rd, exp_status(1'b0));

        // Drain eight back-to-back frames at divisor 1.
        bus_write(2'd3, 32'h1, e);
        bus_write(2'd2, 32'h1, e);
        for (int k = 0; k < 8; k++) schedule(e + 2 + 11 * k, 1);
        wait_cycles(8 * 11 + 3);
        bus_write(2'd2, 32'h3, e);
        check_eq("irq_drained", 32'(irq), 32'd1);
        bus_read(2'd1, rd); check_eq("status_drained", rd, exp_status(1'b0));

        // Divisor 0 stored as 1; mid-frame divisor change applies to next frame.
        bus_write(2'd3, 32'h0, e);
        bus_read(2'd3, rd); check_eq("div_zero", rd, 32'h1);
        bus_write(2'd3, 32'h3, e);
        b  = 8'($urandom);
        b2 = 8'($urandom);
        bus_write(2'd0, {24'd0, b}, e);
        model_push(b);
        schedule(e + 2, 3);
        wait_cycles(10);
        check_eq("irq_busy", 32'(irq), 32'd0);
        bus_write(2'd0, {24'd0, b2}, e2);
        model_push(b2);
        bus_xfer(2'd3, 32'h7, 3'b110, e2, rd);
        check_eq("rdwr_old_div", rd, 32'h3);
        schedule(e + 33, 7);
        tgt = e + 33 + 70 + 2;
        while (cyc < tgt) @(posedge clk);
        #1;
        bus_read(2'd3, rd); check_eq("div_seven", rd, 32'h7);

        // Asynchronous reset in the middle of the data bits.
        bus_write(2'd3, 32'h4, e);
        b = 8'($urandom) & 8'hFB;
        bus_write(2'd0, {24'd0, b}, e);
        model_push(b);
        schedule(e + 2, 4);
        tgt = e + 14;
        while (cyc < tgt) @(posedge clk);
        #2;
        mon_en = 1'b0;
        check_eq("pre_rst_tx", 32'(tx), 32'd0);
        check_eq("pre_rst_busy", 32'(tx_busy), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("async_tx", 32'(tx), 32'd1);
        check_eq("async_busy", 32'(tx_busy), 32'd0);
        check_eq("async_irq", 32'(irq), 32'd0);
        @(negedge clk) rst = 1'b1;
        mq.delete();
        fr_start.delete();
        fr_per.delete();
        fr_byte.delete();
        m_ovf = 1'b0;
        bus_read(2'd1, rd); check_eq("post_rst_status", rd, exp_status(1'b0));
        bus_read(2'd2, rd); check_eq("post_rst_ctrl", rd, 32'h0);
        bus_read(2'd3, rd); check_eq("post_rst_div", rd, 32'h4);
        check_eq("post_rst_tx", 32'(tx), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
